// File: rtl/hex_page_scheduler.sv
// hex_page_scheduler: selects one of N_CH requester channels for an eight-digit
// hex display. Each channel owns a shadow word pair; the shown page rotates on a
// dwell timer, a manual step edge, or jumps on an alert from an enabled channel.
module hex_page_scheduler #(
    parameter int N_CH  = 4,
    parameter int DWELL = 50_000_000
) (
    input  logic                Clk,
    input  logic                Reset,
    input  logic [N_CH-1:0]     ch_load,
    input  logic [16*N_CH-1:0]  ch_a,
    input  logic [16*N_CH-1:0]  ch_b,
    input  logic [N_CH-1:0]     ch_en,
    input  logic [N_CH-1:0]     alert,
    input  logic                step,
    input  logic                auto_en,
    input  logic                freeze,
    output logic [15:0]         disp_a,
    output logic [15:0]         disp_b,
    output logic [2:0]          page,
    output logic                page_valid
);

    localparam int CW = $clog2(DWELL);
    localparam int PW = $clog2(N_CH);
    localparam logic [CW-1:0] CNT_LAST = CW'(DWELL - 1);

    typedef enum logic {IDLE, SHOW} state_t;

    state_t          state, stateNext;
    logic [2:0]      pageNext;
    logic [CW-1:0]   dwellCnt, dwellCntNext;
    logic            stepPrev;
    logic            stepEdge;
    logic [N_CH-1:0] alertHits;
    logic [15:0]     dispANext, dispBNext;
    logic [15:0]     shadowA [N_CH];
    logic [15:0]     shadowB [N_CH];

    // Lowest set bit of a channel mask (0 when the mask is empty).
    function automatic logic [2:0] lowestEn(input logic [N_CH-1:0] en);
        logic [2:0] lo;
        lo = '0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (en[i]) lo = 3'(i);
        end
        return lo;
    endfunction

    // Lowest enabled index above cur, wrapping to the lowest enabled index;
    // returns cur itself when it is the only enabled channel.
    function automatic logic [2:0] nextEn(input logic [N_CH-1:0] en, input logic [2:0] cur);
        logic [2:0] lo;
        logic [2:0] hi;
        logic       hiFound;
        lo      = cur;
        hi      = cur;
        hiFound = 1'b0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (en[i]) lo = 3'(i);
            if (en[i] && (3'(i) > cur)) begin
                hi      = 3'(i);
                hiFound = 1'b1;
            end
        end
        return hiFound ? hi : lo;
    endfunction

    assign stepEdge   = step & ~stepPrev;
    assign alertHits  = alert & ch_en;
    assign page_valid = (state == SHOW);

    // Per-channel shadow capture, independent of enable, freeze and FSM state.
    generate
        for (genvar gi = 0; gi < N_CH; gi++) begin : g_shadow
            always_ff @(posedge Clk or posedge Reset) begin
                if (Reset) begin
                    shadowA[gi] <= '0;
                    shadowB[gi] <= '0;
                end else if (ch_load[gi]) begin
                    shadowA[gi] <= ch_a[16*gi +: 16];
                    shadowB[gi] <= ch_b[16*gi +: 16];
                end
            end
        end
    endgenerate

    // Next-state, page selection, dwell timing and display source, in priority order.
    always_comb begin
        stateNext    = state;
        pageNext     = page;
        dwellCntNext = dwellCnt;
        dispANext    = disp_a;
        dispBNext    = disp_b;
        if (ch_en == '0) begin
            stateNext    = IDLE;
            pageNext     = '0;
            dwellCntNext = '0;
            dispANext    = '0;
            dispBNext    = '0;
        end else begin
            // Display follows the page held during the current cycle.
            if (!freeze) begin
                dispANext = (state == SHOW) ? shadowA[page[PW-1:0]] : '0;
                dispBNext = (state == SHOW) ? shadowB[page[PW-1:0]] : '0;
            end
            case (state)
                IDLE: begin
                    stateNext    = SHOW;
                    pageNext     = lowestEn(ch_en);
                    dwellCntNext = '0;
                end
                SHOW: begin
                    if (alertHits != '0) begin
                        pageNext     = lowestEn(alertHits);
                        dwellCntNext = '0;
                    end else if (stepEdge || !ch_en[page[PW-1:0]]) begin
                        // A step, or the current page losing its enable, both move on.
                        pageNext     = nextEn(ch_en, page);
                        dwellCntNext = '0;
                    end else if (auto_en) begin
                        if (dwellCnt == CNT_LAST) begin
                            pageNext     = nextEn(ch_en, page);
                            dwellCntNext = '0;
                        end else begin
                            dwellCntNext = dwellCnt + 1'b1;
                        end
                    end else begin
                        dwellCntNext = '0;
                    end
                end
                default: stateNext = IDLE;
            endcase
        end
    end

    // State, page, dwell counter, step history and display registers.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state    <= IDLE;
            page     <= '0;
            dwellCnt <= '0;
            stepPrev <= 1'b0;
            disp_a   <= '0;
            disp_b   <= '0;
        end else begin
            state    <= stateNext;
            page     <= pageNext;
            dwellCnt <= dwellCntNext;
            stepPrev <= step;
            disp_a   <= dispANext;
            disp_b   <= dispBNext;
        end
    end

endmodule

// File: tb/tb_hex_page_scheduler.sv
// Self-checking bench for hex_page_scheduler (N_CH=4, DWELL=4): directed table,
// hand-written corner sequences and randomized traffic against a reference model.
module tb_hex_page_scheduler;

    localparam int NCH   = 4;
    localparam int DW    = 4;

    logic          Clk = 1'b0;
    logic          Reset = 1'b1;
    logic [3:0]    ch_load = '0;
    logic [63:0]   ch_a = '0;
    logic [63:0]   ch_b = '0;
    logic [3:0]    ch_en = '0;
    logic [3:0]    alert = '0;
    logic          step = 1'b0;
    logic          auto_en = 1'b0;
    logic          freeze = 1'b0;
    logic [15:0]   disp_a, disp_b;
    logic [2:0]    page;
    logic          page_valid;

    int vecs = 0;
    int miss = 0;

    // Reference model state
    bit          mValid;
    int          mPage;
    int          mCnt;
    bit          mStepPrev;
    logic [15:0] mShA [4];
    logic [15:0] mShB [4];
    logic [15:0] mDispA, mDispB;

    typedef struct {
        logic [3:0] en;
        logic [3:0] al;
        logic       st;
        logic [2:0] ePage;
        logic       eValid;
    } vec_t;
    vec_t tbl [13];

    hex_page_scheduler #(.N_CH(NCH), .DWELL(DW)) dut (
        .Clk(Clk), .Reset(Reset), .ch_load(ch_load), .ch_a(ch_a), .ch_b(ch_b),
        .ch_en(ch_en), .alert(alert), .step(step), .auto_en(auto_en), .freeze(freeze),
        .disp_a(disp_a), .disp_b(disp_b), .page(page), .page_valid(page_valid)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            miss++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic chkAll(input string nm, input int ep, input bit ev,
                          input logic [15:0] ea, input logic [15:0] eb);
        chk({nm, ".page"}, 32'(page), 32'(ep));
        chk({nm, ".valid"}, 32'(page_valid), 32'(ev));
        chk({nm, ".disp_a"}, 32'(disp_a), 32'(ea));
        chk({nm, ".disp_b"}, 32'(disp_b), 32'(eb));
    endtask

    // Rotational search from the slot after cur: first enabled channel found.
    function automatic int rotNext(input logic [3:0] en, input int cur);
        for (int off = 1; off <= 4; off++) begin
            int idx;
            idx = (cur + off) % 4;
            if (en[idx]) return idx;
        end
        return cur;
    endfunction

    function automatic int lowestOf(input logic [3:0] m);
        for (int i = 0; i < 4; i++) if (m[i]) return i;
        return 0;
    endfunction

    task automatic modelReset();
        mValid = 0; mPage = 0; mCnt = 0; mStepPrev = 0;
        mDispA = '0; mDispB = '0;
        for (int i = 0; i < 4; i++) begin
            mShA[i] = '0;
            mShB[i] = '0;
        end
    endtask

    // One clock edge of the behavioural rules, using the inputs now applied.
    task automatic modelStep();
        int np, nc;
        bit nv, stepEdge;
        logic [15:0] nda, ndb;
        np = mPage; nc = mCnt; nv = mValid; nda = mDispA; ndb = mDispB;
        stepEdge = step && !mStepPrev;
        if (ch_en == 4'b0) begin
            nv = 0; np = 0; nc = 0; nda = '0; ndb = '0;
        end else begin
            if (!freeze) begin
                nda = mValid ? mShA[mPage] : 16'h0;
                ndb = mValid ? mShB[mPage] : 16'h0;
            end
            if (!mValid) begin
                nv = 1; np = lowestOf(ch_en); nc = 0;
            end else if ((alert & ch_en) != 4'b0) begin
                np = lowestOf(alert & ch_en); nc = 0;
            end else if (stepEdge || !ch_en[mPage]) begin
                np = rotNext(ch_en, mPage); nc = 0;
            end else if (auto_en) begin
                if (mCnt == DW - 1) begin
                    np = rotNext(ch_en, mPage); nc = 0;
                end else begin
                    nc = mCnt + 1;
                end
            end else begin
                nc = 0;
            end
        end
        for (int k = 0; k < 4; k++) begin
            if (ch_load[k]) begin
                mShA[k] = ch_a[16*k +: 16];
                mShB[k] = ch_b[16*k +: 16];
            end
        end
        mStepPrev = step;
        mValid = nv; mPage = np; mCnt = nc; mDispA = nda; mDispB = ndb;
    endtask

    task automatic tick();
        modelStep();
        @(posedge Clk);
        #1;
    endtask

    task automatic doReset();
        Reset = 1'b1;
        ch_load = '0; ch_a = '0; ch_b = '0; ch_en = '0; alert = '0;
        step = 1'b0; auto_en = 1'b0; freeze = 1'b0;
        modelReset();
        @(posedge Clk);
        #1;
        Reset = 1'b0;
    endtask

    initial begin
        tbl[0]  = '{4'b1010, 4'b0000, 1'b0, 3'd1, 1'b1};
        tbl[1]  = '{4'b1010, 4'b0000, 1'b1, 3'd3, 1'b1};
        tbl[2]  = '{4'b1010, 4'b0000, 1'b1, 3'd3, 1'b1};
        tbl[3]  = '{4'b1010, 4'b0000, 1'b0, 3'd3, 1'b1};
        tbl[4]  = '{4'b1010, 4'b0000, 1'b1, 3'd1, 1'b1};
        tbl[5]  = '{4'b1010, 4'b0100, 1'b0, 3'd1, 1'b1};
        tbl[6]  = '{4'b1010, 4'b1000, 1'b0, 3'd3, 1'b1};
        tbl[7]  = '{4'b1000, 4'b0000, 1'b0, 3'd3, 1'b1};
        tbl[8]  = '{4'b0010, 4'b0000, 1'b0, 3'd1, 1'b1};
        tbl[9]  = '{4'b0000, 4'b0000, 1'b0, 3'd0, 1'b0};
        tbl[10] = '{4'b0110, 4'b0000, 1'b0, 3'd1, 1'b1};
        tbl[11] = '{4'b0110, 4'b0000, 1'b1, 3'd2, 1'b1};
        tbl[12] = '{4'b0110, 4'b0000, 1'b0, 3'd2, 1'b1};

        // Reset state, checked while reset is held
        modelReset();
        #1;
        chkAll("reset", 0, 0, 16'h0, 16'h0);
        doReset();

        // Directed table, manual mode
        for (int i = 0; i < 13; i++) begin
            ch_en = tbl[i].en; alert = tbl[i].al; step = tbl[i].st; auto_en = 1'b0;
            tick();
            chk($sformatf("tbl%0d.page", i), 32'(page), 32'(tbl[i].ePage));
            chk($sformatf("tbl%0d.valid", i), 32'(page_valid), 32'(tbl[i].eValid));
            if (i == 0) chkAll("first_show", 1, 1, 16'h0, 16'h0);
        end

        // Auto rotation: each page held exactly DWELL cycles
        doReset();
        ch_en = 4'b1111; auto_en = 1'b1;
        for (int k = 1; k <= 17; k++) begin
            tick();
            chk($sformatf("rot%0d.page", k), 32'(page), 32'(((k - 1) / 4) % 4));
        end

        // Load to display latency: two edges
        doReset();
        ch_en = 4'b0100;
        tick();
        ch_load = 4'b0100; ch_a[47:32] = 16'h1234; ch_b[47:32] = 16'hABCD;
        tick();
        ch_load = '0;
        chkAll("load_edge1", 2, 1, 16'h0, 16'h0);
        tick();
        chkAll("load_edge2", 2, 1, 16'h1234, 16'hABCD);

        // Alert, step edge and dwell expiry in one cycle
        doReset();
        ch_en = 4'b1111; auto_en = 1'b1;
        for (int k = 0; k < 4; k++) tick();
        alert = 4'b0110; step = 1'b1;
        tick();
        alert = '0; step = 1'b0;
        chk("prio.page", 32'(page), 32'd1);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk($sformatf("prio_hold%0d", k), 32'(page), 32'd1);
        end
        tick();
        chk("prio_next", 32'(page), 32'd2);

        // Freeze holds display while page moves, catches up in one edge
        doReset();
        ch_en = 4'b1111;
        ch_load = 4'b1001;
        ch_a[15:0] = 16'h1111; ch_b[15:0] = 16'h2222;
        ch_a[63:48] = 16'h3333; ch_b[63:48] = 16'h4444;
        tick();
        ch_load = '0;
        tick();
        chkAll("frz_pre", 0, 1, 16'h1111, 16'h2222);
        freeze = 1'b1; alert = 4'b1000;
        tick();
        alert = '0;
        chkAll("frz_jump", 3, 1, 16'h1111, 16'h2222);
        tick();
        chkAll("frz_hold", 3, 1, 16'h1111, 16'h2222);
        freeze = 1'b0;
        tick();
        chkAll("frz_release", 3, 1, 16'h3333, 16'h4444);

        // Last enable drops: back to idle with blank display
        doReset();
        ch_en = 4'b0100;
        ch_load = 4'b0100; ch_a[47:32] = 16'h5555; ch_b[47:32] = 16'h6666;
        tick();
        ch_load = '0;
        tick();
        chkAll("idle_pre", 2, 1, 16'h5555, 16'h6666);
        ch_en = 4'b0000;
        tick();
        chkAll("to_idle", 0, 0, 16'h0, 16'h0);

        // Reset mid-dwell clears outputs immediately and discards progress
        ch_en = 4'b1111; auto_en = 1'b1;
        ch_load = 4'b0001; ch_a[15:0] = 16'h7777; ch_b[15:0] = 16'h8888;
        tick();
        ch_load = '0;
        tick();
        tick();
        chkAll("mid_pre", 0, 1, 16'h7777, 16'h8888);
        #2;
        Reset = 1'b1;
        modelReset();
        #1;
        chkAll("mid_reset", 0, 0, 16'h0, 16'h0);
        @(posedge Clk);
        #1;
        Reset = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            tick();
            chk($sformatf("post_rst%0d", k), 32'(page), (k == 5) ? 32'd1 : 32'd0);
        end

        // Randomized traffic against the reference model
        doReset();
        ch_en = 4'b1111; auto_en = 1'b1;
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(0, 7) == 0) ch_en = 4'($urandom_range(0, 15));
            alert   = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(1, 15)) : 4'b0;
            if ($urandom_range(0, 3) == 0) step = ~step;
            if ($urandom_range(0, 19) == 0) auto_en = ~auto_en;
            freeze  = ($urandom_range(0, 7) == 0);
            ch_load = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'b0;
            ch_a    = {$urandom, $urandom};
            ch_b    = {$urandom, $urandom};
            tick();
            chkAll($sformatf("rnd%0d", n), mPage, mValid, mDispA, mDispB);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
        $finish;
    end

endmodule
